// File: rtl/axis_fifo_pkg.sv
// Shared defaults and sizing helpers for the AXI-Stream downsizing FIFO.
package axis_fifo_pkg;

  localparam int DEF_IN_WIDTH   = 80;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_USER_WIDTH = 1;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Address/counter width that never collapses to zero for single-entry sizes.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage: registered write port, asynchronous read port (data written on an edge is readable the next cycle).
module axis_fifo_ram #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 2,
  parameter int AW      = 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_dat
);

  logic [WIDTH-1:0] r_mem [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_downsize_fifo.sv
// Wide-beat FIFO emitting RATIO narrow words per beat; first-word-fall-through, S_TREADY registered from entry count.
// AXIS_DOWNSIZE_MSB_FIRST_EN selects MSB-first lane order (default LSB-first).
module axis_downsize_fifo
  import axis_fifo_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [IN_WIDTH-1:0]     S_TDATA,
  input  logic                    S_TVALID,
  output logic                    S_TREADY,
  input  logic [USER_WIDTH-1:0]   S_TUSER,
  input  logic                    S_TLAST,
  output logic [OUT_WIDTH-1:0]    M_TDATA,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic [USER_WIDTH-1:0]   M_TUSER,
  output logic                    M_TLAST,
  output logic [$clog2(DEPTH):0]  LEVEL
);

  localparam int RATIO   = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int ENTRIES = DEPTH / RATIO;
  localparam int AW      = calc_aw(ENTRIES);
  localparam int LW      = calc_aw(RATIO);
  localparam int CW      = $clog2(ENTRIES + 1);
  localparam int RW      = IN_WIDTH + USER_WIDTH + 1;
  localparam int LVW     = $clog2(DEPTH) + 1;

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [LW-1:0]         r_lane;
  logic                  r_s_tready;

  logic                  w_push;
  logic                  w_m_valid;
  logic                  w_m_xfer;
  logic                  w_last_lane;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;
  logic [RW-1:0]         w_rd_dat;
  logic [IN_WIDTH-1:0]   w_head_data;
  logic [USER_WIDTH-1:0] w_head_user;
  logic                  w_head_last;
  logic [OUT_WIDTH-1:0]  w_word;

  assign w_push      = S_TVALID & r_s_tready;
  assign w_m_valid   = (r_count != '0);
  assign w_m_xfer    = w_m_valid & M_TREADY;
  assign w_last_lane = (r_lane == LW'(RATIO - 1));
  assign w_pop       = w_m_xfer & w_last_lane;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Ready looks at the post-edge count so a final-lane pop reopens the slave side one cycle later.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      r_s_tready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_s_tready <= (w_count_nxt < CW'(ENTRIES));
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(ENTRIES - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(ENTRIES - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      if (w_m_xfer) begin
        r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
      end
    end
  end

  axis_fifo_ram #(
    .WIDTH   (RW),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_ram (
    .i_clk     (ACLK),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  ({S_TLAST, S_TUSER, S_TDATA}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_dat)
  );

  assign w_head_data = w_rd_dat[IN_WIDTH-1:0];
  assign w_head_user = w_rd_dat[IN_WIDTH +: USER_WIDTH];
  assign w_head_last = w_rd_dat[RW-1];

  always_comb begin
    w_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (r_lane == LW'(k)) begin
`ifdef AXIS_DOWNSIZE_MSB_FIRST_EN
        w_word = w_head_data[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
        w_word = w_head_data[k*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  assign S_TREADY = r_s_tready;
  assign M_TVALID = w_m_valid;
  assign M_TDATA  = w_word;
  assign M_TUSER  = (w_m_valid && (r_lane == '0)) ? w_head_user : '0;
  assign M_TLAST  = w_m_valid & w_last_lane & w_head_last;
  assign LEVEL    = LVW'(r_count) * LVW'(RATIO) - LVW'(r_lane);

endmodule
